fetch_sequencer: RTL and testbench

Multi-cycle fetch/PC sequencer for the RV32I core. It owns the architectural PC and issues instruction-memory requests over a req/ready + rvalid handshake. It holds the fetched instruction until the core signals completion, then selects the next PC from the 2-bit pc_control redirect code. It also detects misaligned targets, imem bus errors and imem timeouts, and supports halt.

---
 rtl/fetch_sequencer_pkg.sv | 26 ++
 rtl/fetch_sequencer_pc_next_select.sv | 27 ++
 rtl/fetch_sequencer.sv | 158 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared encodings for the fetch sequencer and the main control unit:
// sequencer states, pc_control redirect codes and fault cause codes.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_REQ    = 2'd0,
    ST_WAIT   = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JAL    = 2'b10;
  localparam logic [1:0] PC_JALR   = 2'b11;

  localparam logic [1:0] CAUSE_NONE       = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGNED = 2'b01;
  localparam logic [1:0] CAUSE_BUS_ERR    = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT    = 2'b11;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_sequencer_pc_next_select.sv
// Combinational next-PC mux driven by the pc_control redirect code,
// with word-alignment check of the selected target.
module pc_next_select
  import fetch_sequencer_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pc_control,
  input  logic [31:0] target_addr,
  input  logic [31:0] jalr_addr,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  always_comb begin
    next_pc = pc + 32'd4;
    case (pc_control)
      PC_PLUS4:  next_pc = pc + 32'd4;
      PC_BRANCH: next_pc = target_addr;
      PC_JAL:    next_pc = target_addr;
      // jalr clears bit 0 of rs1+imm before use
      PC_JALR:   next_pc = jalr_addr & ~32'h1;
      default:   next_pc = pc + 32'd4;
    endcase
    misaligned = is_misaligned(next_pc);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/PC sequencer: REQ -> WAIT -> EXEC per instruction,
// with misaligned/bus-error/timeout traps to TRAP_VECTOR and halt support.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR    = 32'h0000_0100,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rerr,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  input  logic        instr_done,
  input  logic [1:0]  pc_control,
  input  logic [31:0] target_addr,
  input  logic [31:0] jalr_addr,
  input  logic        halt_req,
  output logic        halted,
  output logic        fault_valid,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_addr,
  output logic [31:0] instret
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instret_q, instret_d;
  logic [31:0]  fault_addr_q, fault_addr_d;
  logic [1:0]   fault_cause_q, fault_cause_d;
  logic         fault_valid_q, fault_valid_d;
  logic         halted_q, halted_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [31:0] next_pc;
  logic        next_misaligned;

  pc_next_select u_pc_next_select (
    .pc          (pc_q),
    .pc_control  (pc_control),
    .target_addr (target_addr),
    .jalr_addr   (jalr_addr),
    .next_pc     (next_pc),
    .misaligned  (next_misaligned)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instret_d     = instret_q;
    fault_addr_d  = fault_addr_q;
    fault_cause_d = fault_cause_q;
    fault_valid_d = 1'b0;
    halted_d      = halted_q;
    cnt_d         = cnt_q;

    case (state_q)
      ST_REQ: begin
        if (imem_ready) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A response arriving on the timeout cycle is still accepted.
        if (imem_rvalid) begin
          if (!imem_rerr) begin
            instr_d = imem_rdata;
            state_d = ST_EXEC;
          end else begin
            fault_valid_d = 1'b1;
            fault_cause_d = CAUSE_BUS_ERR;
            fault_addr_d  = pc_q;
            pc_d          = TRAP_VECTOR;
            state_d       = ST_REQ;
          end
        end else if (cnt_q == CNT_LAST) begin
          fault_valid_d = 1'b1;
          fault_cause_d = CAUSE_TIMEOUT;
          fault_addr_d  = pc_q;
          pc_d          = TRAP_VECTOR;
          state_d       = ST_REQ;
        end
      end
      ST_EXEC: begin
        if (instr_done) begin
          instret_d = instret_q + 32'd1;
          if (halt_req) begin
            state_d  = ST_HALTED;
            halted_d = 1'b1;
          end else if (next_misaligned) begin
            fault_valid_d = 1'b1;
            fault_cause_d = CAUSE_MISALIGNED;
            fault_addr_d  = next_pc;
            pc_d          = TRAP_VECTOR;
            state_d       = ST_REQ;
          end else begin
            pc_d    = next_pc;
            state_d = ST_REQ;
          end
        end
      end
      ST_HALTED: begin
        halted_d = 1'b1;
      end
      default: state_d = ST_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_REQ;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instret_q     <= '0;
      fault_addr_q  <= '0;
      fault_cause_q <= CAUSE_NONE;
      fault_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instret_q     <= instret_d;
      fault_addr_q  <= fault_addr_d;
      fault_cause_q <= fault_cause_d;
      fault_valid_q <= fault_valid_d;
      halted_q      <= halted_d;
      cnt_q         <= cnt_d;
    end
  end

  assign imem_req    = (state_q == ST_REQ);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == ST_EXEC);
  assign instr       = instr_q;
  assign pc_out      = pc_q;
  assign halted      = halted_q;
  assign fault_valid = fault_valid_q;
  assign fault_cause = fault_cause_q;
  assign fault_addr  = fault_addr_q;
  assign instret     = instret_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; one task per scenario.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_rerr;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic        instr_done;
  logic [1:0]  pc_control;
  logic [31:0] target_addr;
  logic [31:0] jalr_addr;
  logic        halt_req;
  logic        halted;
  logic        fault_valid;
  logic [1:0]  fault_cause;
  logic [31:0] fault_addr;
  logic [31:0] instret;

  int vecs = 0;
  int miss = 0;
  logic [31:0] exp_instret = 32'd0;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .imem_rerr   (imem_rerr),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc_out      (pc_out),
    .instr_done  (instr_done),
    .pc_control  (pc_control),
    .target_addr (target_addr),
    .jalr_addr   (jalr_addr),
    .halt_req    (halt_req),
    .halted      (halted),
    .fault_valid (fault_valid),
    .fault_cause (fault_cause),
    .fault_addr  (fault_addr),
    .instret     (instret)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // REQ accepted, then a clean response one cycle later; ends in EXEC.
  task automatic fetch(input logic [31:0] word);
    imem_ready = 1'b1;
    step();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    imem_rerr   = 1'b0;
    step();
    imem_rvalid = 1'b0;
  endtask

  task automatic retire(input logic [1:0] ctrl, input logic [31:0] tgt,
                        input logic [31:0] jalr, input logic halt);
    instr_done  = 1'b1;
    pc_control  = ctrl;
    target_addr = tgt;
    jalr_addr   = jalr;
    halt_req    = halt;
    step();
    instr_done = 1'b0;
    halt_req   = 1'b0;
    exp_instret = exp_instret + 32'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_instret = 32'd0;
  endtask

  task automatic test_reset();
    do_reset();
    vecs++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0 ||
        halted !== 1'b0 || fault_valid !== 1'b0) begin
      miss++;
      $display("FAIL reset_ctl: req=%b addr=%h iv=%b halted=%b fv=%b, required 1 00000000 0 0 0",
               imem_req, imem_addr, instr_valid, halted, fault_valid);
    end
    vecs++;
    if (instr !== 32'h0 || instret !== 32'h0 || fault_addr !== 32'h0 || fault_cause !== 2'b00) begin
      miss++;
      $display("FAIL reset_regs: instr=%h instret=%0d faddr=%h cause=%b, required 0 0 0 00",
               instr, instret, fault_addr, fault_cause);
    end
    $display("reset: addr=%h instret=%0d", imem_addr, instret);
  endtask

  task automatic test_basic_fetch();
    fetch(32'h0050_0093);
    vecs++;
    if (instr_valid !== 1'b1 || instr !== 32'h0050_0093 || pc_out !== 32'h0) begin
      miss++;
      $display("FAIL first_exec: iv=%b instr=%h pc_out=%h, required 1 00500093 00000000",
               instr_valid, instr, pc_out);
    end
    // core stalls: instruction must stay stable
    pc_control = 2'b01;
    target_addr = 32'h0000_0777;
    repeat (3) step();
    vecs++;
    if (instr_valid !== 1'b1 || instr !== 32'h0050_0093 || imem_req !== 1'b0 || instret !== 32'd0) begin
      miss++;
      $display("FAIL exec_hold: iv=%b instr=%h req=%b instret=%0d, required 1 00500093 0 0",
               instr_valid, instr, imem_req, instret);
    end
    retire(2'b00, 32'h0, 32'h0, 1'b0);
    vecs++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instret !== exp_instret) begin
      miss++;
      $display("FAIL seq_pc4: req=%b addr=%h instret=%0d, required 1 00000004 %0d",
               imem_req, imem_addr, instret, exp_instret);
    end
    $display("basic: fetched 00500093 at 0, next addr=%h instret=%0d", imem_addr, instret);
  endtask

  task automatic test_redirect();
    fetch(32'h0000_0013);
    retire(2'b01, 32'h0000_0010, 32'h0, 1'b0);
    fetch(32'h0000_0063);
    vecs++;
    if (pc_out !== 32'h10) begin
      miss++;
      $display("FAIL pc_out_0x10: pc_out=%h, required 00000010", pc_out);
    end
    retire(2'b01, 32'h0000_0040, 32'h0000_0999, 1'b0);
    vecs++;
    if (imem_addr !== 32'h40 || fault_valid !== 1'b0) begin
      miss++;
      $display("FAIL branch: addr=%h fv=%b, required 00000040 0", imem_addr, fault_valid);
    end
    $display("branch: addr=%h", imem_addr);
    fetch(32'h0000_0067);
    retire(2'b11, 32'h0000_0555, 32'h0000_0081, 1'b0);
    vecs++;
    if (imem_addr !== 32'h80 || fault_valid !== 1'b0 || instret !== exp_instret) begin
      miss++;
      $display("FAIL jalr: addr=%h fv=%b instret=%0d, required 00000080 0 %0d",
               imem_addr, fault_valid, instret, exp_instret);
    end
    $display("jalr: addr=%h instret=%0d", imem_addr, instret);
  endtask

  task automatic test_misaligned();
    fetch(32'h0000_006f);
    retire(2'b10, 32'h0000_0042, 32'h0, 1'b0);
    vecs++;
    if (fault_valid !== 1'b1 || fault_cause !== 2'b01 || fault_addr !== 32'h42 ||
        imem_addr !== 32'h100 || instret !== exp_instret) begin
      miss++;
      $display("FAIL misaligned: fv=%b cause=%b faddr=%h addr=%h instret=%0d, required 1 01 00000042 00000100 %0d",
               fault_valid, fault_cause, fault_addr, imem_addr, instret, exp_instret);
    end
    step();
    vecs++;
    if (fault_valid !== 1'b0 || fault_addr !== 32'h42 || imem_req !== 1'b1) begin
      miss++;
      $display("FAIL fault_pulse: fv=%b faddr=%h req=%b, required 0 00000042 1",
               fault_valid, fault_addr, imem_req);
    end
    $display("misaligned: cause=%b faddr=%h", fault_cause, fault_addr);
  endtask

  task automatic test_bus_error();
    fetch(32'h0000_0013);
    retire(2'b01, 32'h0000_0008, 32'h0, 1'b0);
    imem_ready = 1'b1;
    step();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rerr   = 1'b1;
    imem_rdata  = 32'hdead_beef;
    step();
    imem_rvalid = 1'b0;
    imem_rerr   = 1'b0;
    vecs++;
    if (fault_valid !== 1'b1 || fault_cause !== 2'b10 || fault_addr !== 32'h8 ||
        imem_addr !== 32'h100 || imem_req !== 1'b1 || instret !== exp_instret) begin
      miss++;
      $display("FAIL bus_err: fv=%b cause=%b faddr=%h addr=%h req=%b instret=%0d, required 1 10 00000008 00000100 1 %0d",
               fault_valid, fault_cause, fault_addr, imem_addr, imem_req, instret, exp_instret);
    end
    $display("bus_err: cause=%b faddr=%h", fault_cause, fault_addr);
  endtask

  task automatic test_timeout();
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    repeat (15) step();
    vecs++;
    if (fault_valid !== 1'b0 || imem_req !== 1'b0) begin
      miss++;
      $display("FAIL timeout_early: fv=%b req=%b after 15 wait cycles, required 0 0", fault_valid, imem_req);
    end
    step();
    vecs++;
    if (fault_valid !== 1'b1 || fault_cause !== 2'b11 || fault_addr !== 32'h100 || imem_req !== 1'b1) begin
      miss++;
      $display("FAIL timeout: fv=%b cause=%b faddr=%h req=%b, required 1 11 00000100 1",
               fault_valid, fault_cause, fault_addr, imem_req);
    end
    $display("timeout: cause=%b faddr=%h", fault_cause, fault_addr);
    // response on the very last wait cycle beats the timeout
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    repeat (15) step();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0073;
    step();
    imem_rvalid = 1'b0;
    vecs++;
    if (fault_valid !== 1'b0 || instr_valid !== 1'b1 || instr !== 32'h0000_0073) begin
      miss++;
      $display("FAIL rvalid_wins: fv=%b iv=%b instr=%h, required 0 1 00000073",
               fault_valid, instr_valid, instr);
    end
    $display("late rvalid: instr=%h", instr);
  endtask

  task automatic test_halt();
    // sequencer is in EXEC at 0x100 from the previous scenario
    retire(2'b01, 32'h0000_0040, 32'h0, 1'b1);
    vecs++;
    if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 ||
        instret !== exp_instret || fault_valid !== 1'b0) begin
      miss++;
      $display("FAIL halt: halted=%b req=%b iv=%b instret=%0d fv=%b, required 1 0 0 %0d 0",
               halted, imem_req, instr_valid, instret, exp_instret, fault_valid);
    end
    imem_ready  = 1'b1;
    imem_rvalid = 1'b1;
    instr_done  = 1'b1;
    repeat (4) step();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    instr_done  = 1'b0;
    vecs++;
    if (halted !== 1'b1 || imem_req !== 1'b0 || instret !== exp_instret) begin
      miss++;
      $display("FAIL halt_hold: halted=%b req=%b instret=%0d, required 1 0 %0d",
               halted, imem_req, instret, exp_instret);
    end
    $display("halt: halted=%b instret=%0d", halted, instret);
    do_reset();
    vecs++;
    if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0 || instret !== 32'd0) begin
      miss++;
      $display("FAIL halt_reset: halted=%b req=%b addr=%h instret=%0d, required 0 1 00000000 0",
               halted, imem_req, imem_addr, instret);
    end
  endtask

  task automatic test_reset_in_wait();
    fetch(32'h0000_0013);
    retire(2'b01, 32'h0000_0020, 32'h0, 1'b0);
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hbad0_bad0;
    step();
    imem_rvalid = 1'b0;
    vecs++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0 ||
        instr !== 32'h0 || instret !== 32'd0) begin
      miss++;
      $display("FAIL reset_wait: req=%b addr=%h iv=%b instr=%h instret=%0d, required 1 00000000 0 00000000 0",
               imem_req, imem_addr, instr_valid, instr, instret);
    end
    $display("reset in wait: addr=%h instr=%h", imem_addr, instr);
  endtask

  initial begin
    rst = 1'b0;
    imem_ready = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    imem_rerr = 1'b0;
    instr_done = 1'b0;
    pc_control = 2'b00;
    target_addr = 32'h0;
    jalr_addr = 32'h0;
    halt_req = 1'b0;
    test_reset();
    test_basic_fetch();
    test_redirect();
    test_misaligned();
    test_bus_error();
    test_timeout();
    test_halt();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
